// File: rtl/pin_entry_auth.sv
// PIN entry and authentication front-end for the ATM PIN stage.
// Collects BCD digits from the keypad, compares them with the card's
// reference PIN, tracks failed attempts and locks the card after too many
// consecutive failures. An idle COLLECT session aborts after a timeout.
//
// Keypad handshake: i_key_valid, i_key_clear and i_key_enter are one-cycle
// strobes. They are only acted on in COLLECT and have no backpressure.
// Priority within one cycle is clear > enter > valid. All result outputs are
// derived from registered state only (Moore). o_dbg_state exposes the FSM
// encoding for observation and checkers.
module pin_entry_auth #(
  parameter int PIN_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_key_valid,
  input  logic [3:0]              i_key_digit,
  input  logic                    i_key_clear,
  input  logic                    i_key_enter,
  input  logic [4*PIN_DIGITS-1:0] i_pin_ref,
  output logic                    o_pin_ok,
  output logic                    o_pin_fail,
  output logic                    o_locked,
  output logic                    o_timeout,
  output logic                    o_busy,
  output logic [2:0]              o_digit_cnt,
  output logic [2:0]              o_tries_left,
  output logic [2:0]              o_dbg_state
);

  localparam int PW = 4 * PIN_DIGITS;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OK      = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;
  localparam logic [2:0] S_LOCKED  = 3'd5;

  localparam logic [2:0] CNT_FULL  = 3'(PIN_DIGITS);
  localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);
  // Timer value seen in the idle cycle that pushes it to TIMEOUT_CYC-1.
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYC - 2);

  logic [2:0]    state;
  logic [PW-1:0] pin_buf;
  logic [2:0]    cnt;
  logic [7:0]    timer;
  logic [2:0]    tries;
  logic          timeout_q;
  logic          digit_legal;
  logic          pin_match;

  assign digit_legal = (i_key_digit <= 4'd9);
  assign pin_match   = (cnt == CNT_FULL) && (pin_buf == i_pin_ref);

  // Main FSM: state transitions, digit buffer, inactivity timer and tries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pin_buf   <= '0;
      cnt       <= '0;
      timer     <= '0;
      tries     <= TRIES_MAX;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state   <= S_COLLECT;
            pin_buf <= '0;
            cnt     <= '0;
            timer   <= '0;
          end
        end
        S_COLLECT: begin
          if (i_key_clear) begin
            pin_buf <= '0;
            cnt     <= '0;
            timer   <= '0;
          end else if (i_key_enter) begin
            state <= S_CHECK;
          end else if (i_key_valid) begin
            // Any key press is activity, even when the digit is discarded.
            timer <= '0;
            if (digit_legal && (cnt < CNT_FULL)) begin
              pin_buf <= {pin_buf[PW-5:0], i_key_digit};
              cnt     <= cnt + 3'd1;
            end
          end else if (timer == TMO_LAST) begin
            state     <= S_IDLE;
            timeout_q <= 1'b1;
            pin_buf   <= '0;
            cnt       <= '0;
            timer     <= '0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_CHECK: begin
          if (pin_match) begin
            state <= S_OK;
            tries <= TRIES_MAX;
          end else begin
            state <= S_FAIL;
            if (tries != 3'd0) tries <= tries - 3'd1;
          end
        end
        S_OK: begin
          state   <= S_IDLE;
          pin_buf <= '0;
          cnt     <= '0;
        end
        S_FAIL: begin
          state   <= (tries == 3'd0) ? S_LOCKED : S_COLLECT;
          pin_buf <= '0;
          cnt     <= '0;
          timer   <= '0;
        end
        S_LOCKED: begin
          state <= S_LOCKED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pin_ok     = (state == S_OK);
  assign o_pin_fail   = (state == S_FAIL);
  assign o_locked     = (state == S_LOCKED);
  assign o_timeout    = timeout_q;
  assign o_busy       = (state != S_IDLE) && (state != S_LOCKED);
  assign o_digit_cnt  = cnt;
  assign o_tries_left = tries;
  assign o_dbg_state  = state;

endmodule

// File: tb/tb_pin_entry_auth.sv
// Scoreboard bench for pin_entry_auth: drivers push expected result pulses
// (ok/fail/timeout with tries and arrival cycle), a negedge monitor pops
// and compares whenever the DUT raises a pulse.
module tb_pin_entry_auth;

  localparam int PIN_DIGITS  = 4;
  localparam int MAX_TRIES   = 3;
  localparam int TIMEOUT_CYC = 200;
  localparam int W           = 6;   // {ok, fail, timeout, tries[2:0]}

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOCKED = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_key_valid = 1'b0;
  logic [3:0]  i_key_digit = 4'd0;
  logic        i_key_clear = 1'b0;
  logic        i_key_enter = 1'b0;
  logic [15:0] i_pin_ref = 16'h1234;
  logic        o_pin_ok, o_pin_fail, o_locked, o_timeout, o_busy;
  logic [2:0]  o_digit_cnt, o_tries_left, o_dbg_state;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  pin_entry_auth #(
    .PIN_DIGITS(PIN_DIGITS), .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_key_valid(i_key_valid),
    .i_key_digit(i_key_digit), .i_key_clear(i_key_clear),
    .i_key_enter(i_key_enter), .i_pin_ref(i_pin_ref), .o_pin_ok(o_pin_ok),
    .o_pin_fail(o_pin_fail), .o_locked(o_locked), .o_timeout(o_timeout),
    .o_busy(o_busy), .o_digit_cnt(o_digit_cnt), .o_tries_left(o_tries_left),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (o_pin_ok || o_pin_fail || o_timeout) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {o_pin_ok, o_pin_fail, o_timeout, o_tries_left}, 0);
      end else begin
        logic [W-1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("pulse_event", {o_pin_ok, o_pin_fail, o_timeout, o_tries_left}, e);
        check("pulse_cycle", cyc, ec);
      end
    end
  end

  // Drive one cycle of inputs; c returns the cycle count before the edge.
  task automatic drive(input logic s, input logic v, input logic [3:0] d,
                       input logic cl, input logic en, output int c);
    c = cyc;
    i_start = s; i_key_valid = v; i_key_digit = d;
    i_key_clear = cl; i_key_enter = en;
    @(posedge clk); #1;
    i_start = 1'b0; i_key_valid = 1'b0; i_key_digit = 4'd0;
    i_key_clear = 1'b0; i_key_enter = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start();
    int c;
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, c);
  endtask

  task automatic key(input logic [3:0] d, output int c);
    drive(1'b0, 1'b1, d, 1'b0, 1'b0, c);
  endtask

  task automatic keys4(input logic [15:0] v);
    int c;
    for (int i = 3; i >= 0; i--) key(v[i*4 +: 4], c);
  endtask

  // Enter; when push is set, the expected ok/fail pulse two cycles later is queued.
  task automatic enter(input logic push, input logic ok, input logic [2:0] tries);
    int c;
    if (push) begin
      exp_q.push_back({ok, ~ok, 1'b0, tries});
      exp_cyc_q.push_back(cyc + 2);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, c);
  endtask

  task automatic expect_timeout(input int key_cyc, input logic [2:0] tries);
    exp_q.push_back({1'b0, 1'b0, 1'b1, tries});
    exp_cyc_q.push_back(key_cyc + TIMEOUT_CYC);
  endtask

  // Wait (bounded) until all expected pulses have been seen.
  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_tries"}, o_tries_left, MAX_TRIES);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_cnt"}, o_digit_cnt, 0);
    check({tag, "_state"}, o_dbg_state, ST_IDLE);
  endtask

  initial begin
    int c;
    do_reset();
    idle(1);
    check_idle_reset("reset");
    check("reset_pulses", {o_pin_ok, o_pin_fail, o_timeout}, 0);

    // Correct PIN.
    start();
    keys4(16'h1234);
    check("full_cnt", o_digit_cnt, 4);
    check("collect_busy", o_busy, 1);
    enter(1'b1, 1'b1, 3'd3);
    drain(10);
    check_idle_reset("after_ok");

    // Short entry fails, then 5th digit and illegal digit are ignored.
    start();
    keys4(16'h0123);   // presses 0,1,2,3 -> buffer 0123? use exactly 3 keys below instead
    do_reset();
    start();
    key(4'd1, c); key(4'd2, c); key(4'd3, c);
    check("short_cnt", o_digit_cnt, 3);
    enter(1'b1, 1'b0, 3'd2);
    drain(10);
    check("short_back_collect_busy", o_busy, 1);
    check("short_cnt_cleared", o_digit_cnt, 0);
    check("short_tries", o_tries_left, 2);
    keys4(16'h1234);
    key(4'd5, c);
    key(4'hB, c);
    check("overflow_cnt", o_digit_cnt, 4);
    enter(1'b1, 1'b1, 3'd3);
    drain(10);

    // Clear wins over a simultaneous digit.
    start();
    key(4'd9, c); key(4'd9, c);
    drive(1'b0, 1'b1, 4'd7, 1'b1, 1'b0, c);
    check("clear_cnt", o_digit_cnt, 0);
    keys4(16'h1234);
    enter(1'b1, 1'b1, 3'd3);
    drain(10);

    // Enter together with a digit: the digit is dropped, so 1,2,3 fails.
    start();
    key(4'd1, c); key(4'd2, c); key(4'd3, c);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 3'd2});
    exp_cyc_q.push_back(cyc + 2);
    drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, c);
    drain(10);
    keys4(16'h1234);
    enter(1'b1, 1'b1, 3'd3);
    drain(10);

    // Timeout keeps tries: first burn one attempt.
    start();
    enter(1'b1, 1'b0, 3'd2);
    drain(10);
    key(4'd1, c);
    expect_timeout(c, 3'd2);
    drain(TIMEOUT_CYC + 10);
    check("tmo_cnt", o_digit_cnt, 0);
    check("tmo_busy", o_busy, 0);
    check("tmo_state", o_dbg_state, ST_IDLE);
    check("tmo_tries", o_tries_left, 2);

    // Key at the last idle cycle restarts the timer.
    start();
    key(4'd1, c);
    idle(TIMEOUT_CYC - 2);
    key(4'd2, c);
    check("restart_cnt", o_digit_cnt, 2);
    check("restart_busy", o_busy, 1);
    expect_timeout(c, 3'd2);
    drain(TIMEOUT_CYC + 10);
    check("restart_tmo_cnt", o_digit_cnt, 0);

    // Lockout after three wrong PINs.
    do_reset();
    check("lock_pre_tries", o_tries_left, 3);
    start();
    for (int t = 2; t >= 0; t--) begin
      keys4(16'h0000);
      enter(1'b1, 1'b0, 3'(t));
      drain(10);
    end
    check("locked", o_locked, 1);
    check("locked_busy", o_busy, 0);
    check("locked_tries", o_tries_left, 0);
    check("locked_state", o_dbg_state, ST_LOCKED);
    start();
    keys4(16'h1234);
    enter(1'b0, 1'b0, 3'd0);
    idle(4);
    check("locked_stays", o_locked, 1);
    do_reset();
    check_idle_reset("unlock");

    // Reset while in CHECK: no pulse may follow.
    start();
    keys4(16'h1234);
    enter(1'b0, 1'b0, 3'd0);
    do_reset();
    idle(3);
    check_idle_reset("rst_check");

    // Reset in COLLECT with 3 digits and reduced tries.
    start();
    enter(1'b1, 1'b0, 3'd2);
    drain(10);
    key(4'd1, c); key(4'd2, c); key(4'd3, c);
    check("pre_rst_cnt", o_digit_cnt, 3);
    check("pre_rst_tries", o_tries_left, 2);
    do_reset();
    check_idle_reset("rst_collect");
    idle(3);

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pin_entry_auth.md
Name: pin_entry_auth

Overview:
- Keypad front-end for the ATM controller's PIN stage. Collects PIN digits, compares them against the card's reference PIN and counts failed attempts.
- Emits a one-cycle o_pin_ok pulse that the transaction controller consumes to leave its PIN state.
- Locks the card after MAX_TRIES consecutive failures. Drops the session after an inactivity timeout.

Parameters:
- PIN_DIGITS, 4, number of BCD digits in a PIN.
- MAX_TRIES, 3, consecutive failures allowed before lock (1..7).
- TIMEOUT_CYC, 200, COLLECT cycles with no key event before the session aborts (2..255).

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  card accepted / PIN stage entered; acted on only in IDLE.
- i_key_valid  in  1  one-cycle strobe; i_key_digit is valid.
- i_key_digit  in  4  BCD digit 0..9; values 10..15 are ignored.
- i_key_clear  in  1  one-cycle strobe; erase the digits entered so far.
- i_key_enter  in  1  one-cycle strobe; submit the PIN.
- i_pin_ref  in  4*PIN_DIGITS  reference PIN, first digit in the MS nibble; sampled in CHECK.
- o_pin_ok  out  1  one-cycle pulse: PIN matched.
- o_pin_fail  out  1  one-cycle pulse: attempt rejected.
- o_locked  out  1  level: card locked.
- o_timeout  out  1  one-cycle pulse: session aborted for inactivity.
- o_busy  out  1  high in every state except IDLE and LOCKED.
- o_digit_cnt  out  3  digits currently buffered.
- o_tries_left  out  3  remaining attempts.

Behaviour:
- Reset values:
  - state IDLE, digit buffer 0, digit count 0, timer 0.
  - o_tries_left = MAX_TRIES.
  - All 1-bit outputs 0.
- States: IDLE, COLLECT, CHECK, OK, FAIL, LOCKED. State and all outputs are registered (Moore).
- IDLE:
  - i_start moves to COLLECT; buffer, count and timer are cleared.
  - Key strobes are ignored.
- COLLECT, priority per cycle is clear > enter > valid:
  - clear: count = 0, buffer = 0, timer = 0; stay in COLLECT.
  - enter: go to CHECK with the buffer as is; a digit strobed in the same cycle is dropped.
  - valid with a legal digit and count < PIN_DIGITS: shift the buffer left one nibble, insert the digit at the LS nibble, count += 1, timer = 0.
  - valid with a digit above 9, or with count == PIN_DIGITS: no buffer change; the timer still resets, since the key press counts as activity.
  - No event: timer += 1. When the timer reaches TIMEOUT_CYC-1, go to IDLE. o_timeout pulses in the cycle IDLE is entered. Buffer and count clear. Tries are unchanged.
- CHECK (one cycle):
  - Match requires count == PIN_DIGITS and buffer == i_pin_ref.
  - Match: go to OK and reload tries to MAX_TRIES.
  - Otherwise: go to FAIL and decrement tries, saturating at 0.
- OK (one cycle): o_pin_ok = 1, then IDLE.
  - Latency: enter strobe in cycle t → CHECK at t+1 → o_pin_ok high at t+2.
- FAIL (one cycle): o_pin_fail = 1.
  - If tries == 0, go to LOCKED. Otherwise go to COLLECT with buffer, count and timer cleared.
- LOCKED:
  - o_locked = 1 and o_busy = 0.
  - All inputs are ignored, including i_start. Only rst exits this state.
- o_digit_cnt mirrors the internal count. The buffer contents are never exposed; no PIN data reaches any output.
- Reset mid-entry or in LOCKED returns to the reset values on the next edge.
- Tries persist across timeouts and new i_start sessions; only a success or rst reloads them.

Test Plan:
- Correct PIN:
  - Stimulus: rst, i_start, keys 1,2,3,4, enter; i_pin_ref = 0x1234.
  - Response: o_pin_ok pulses exactly 2 cycles after enter, o_tries_left = 3, then IDLE with o_busy = 0.
- Lockout:
  - Stimulus: three wrong PINs (0,0,0,0 vs 0x1234).
  - Response: o_pin_fail pulses three times, o_tries_left goes 2, 1, 0, then o_locked = 1.
  - Follow-up: a later i_start and the correct PIN produce no o_pin_ok; rst clears o_locked and o_tries_left returns to 3.
- Short and illegal entries:
  - Keys 1,2,3 then enter → o_pin_fail, tries 2, back in COLLECT with o_digit_cnt = 0.
  - Keys 1,2,3,4 then a 5th digit and digit 0xB → o_digit_cnt stays 4; enter → o_pin_ok.
- Clear and priority:
  - Keys 9,9, then clear together with valid, then 1,2,3,4, enter → o_pin_ok; clear wins.
  - enter together with valid → the digit is dropped.
- Timeout:
  - Stimulus: i_start, key 1, then TIMEOUT_CYC-1 idle cycles.
  - Response: o_timeout pulses, IDLE, o_digit_cnt = 0, tries unchanged.
  - A key press at cycle TIMEOUT_CYC-2 restarts the timer.
- Reset mid-operation: rst asserted in CHECK and in COLLECT with 3 digits → next cycle IDLE, all outputs at reset values, no o_pin_ok or o_pin_fail pulse.
